key_search_ctrl: RTL and testbench
==================================

Name: key_search_ctrl

Overview:
Parametrised successor to the single-key message checker: drives a brute-force RC4 key search end to end. For each candidate key it handshakes with the decrypt core, scans the decrypted-message RAM one byte per cycle (pipelined), and accepts the key only if every byte is 'a'-'z' or space. KEY_START/KEY_STEP let several instances partition the key space; a shared stop input aborts losers when any core finds the key.

Parameters:
MSG_LEN, 32, message bytes to check (>=1).
ADDR_W, 5, address width; 2**ADDR_W >= MSG_LEN.
KEY_W, 24, key width.
KEY_START, 0, first key tried.
KEY_STEP, 1, key increment (core count when partitioned).
KEY_MAX, 24'h3FFFFF, highest key that may be tried (inclusive).

Ports:
clk  in  1  system clock, all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin or restart search; sampled only in IDLE, FOUND, FAIL.
stop  in  1  abort search (another core found the key).
dec_start  out  1  one-cycle pulse: decrypt core begins with current key.
dec_done  in  1  decrypt core finished; message RAM valid.
address  out  ADDR_W  message RAM read address.
read_byte  in  8  RAM data; synchronous read, 1-cycle latency.
key  out  KEY_W  current/found key.
busy  out  1  high in DECRYPT, SCAN, NEXT_KEY.
found  out  1  high in FOUND.
fail  out  1  high in FAIL (key space exhausted).
HEX5..HEX0  out  7 each  seven-segment, active-low.
LEDR  out  10  status LEDs.

Behaviour:
- Reset: state IDLE; key=KEY_START; address=0; dec_start, busy, found, fail=0.
- IDLE: start=1 -> key<=KEY_START, DECRYPT.
- DECRYPT: dec_start=1 on first cycle in state only; then wait dec_done (any number of cycles, >=1 after pulse). dec_done=1 -> SCAN with address<=0. dec_done in IDLE/FOUND/FAIL ignored.
- SCAN: address advances 0..MSG_LEN-1, one per cycle; byte for address a checked on cycle after a presented. Valid = 8'h20 or 8'h61..8'h7A inclusive. First invalid byte -> NEXT_KEY immediately (remaining bytes not read). Byte MSG_LEN-1 valid -> FOUND. Full scan of valid key: MSG_LEN+1 cycles in SCAN.
- NEXT_KEY (1 cycle): compute key+KEY_STEP in KEY_W+1 bits; if > KEY_MAX -> FAIL, key unchanged; else key<=key+KEY_STEP, DECRYPT.
- FOUND/FAIL: hold key and flag; start=1 -> clear flag, key<=KEY_START, DECRYPT.
- stop=1 in DECRYPT/SCAN/NEXT_KEY -> IDLE next cycle, found=fail=0, key holds. stop has priority over simultaneous final-valid-byte or exhaustion. stop ignored in IDLE/FOUND/FAIL; stop and start both high in IDLE -> stays IDLE.
- rst_n low mid-operation: immediate return to reset values; dec_start never left high.
- address never exceeds MSG_LEN-1; held at last value outside SCAN.

Optional Feature:
KEY_SEARCH_HEX_DISPLAY_EN. Defined: HEX0..HEX5 show key[3:0]..key[23:20] as hex digits 0-F (key zero-extended if KEY_W<24, upper bits ignored if wider); LEDR[0]=found, LEDR[1]=fail, LEDR[2]=busy, LEDR[9:3]=0. Undefined: HEX* = 7'h7F (blank), LEDR = 0; no decoder logic synthesised.

Test Plan:
- MSG_LEN=4, key 0 bytes 61,62,20,7A; dec_done 3 cycles after dec_start -> found=1, key=0, one dec_start pulse, addresses 0..3 in order.
- Keys 0,1 give 61,62,7B,.. and 61,60,..; key 2 all valid -> found at key=2; exactly 3 dec_start pulses; key 0 abort after byte 2, key 1 after byte 1.
- KEY_START=1, KEY_STEP=4, KEY_MAX=10, always invalid byte 0 -> keys 1,5,9 tried, fail=1, key=9, busy=0.
- stop=1 mid-SCAN at address 2 -> IDLE next cycle, found=fail=busy=0; later start restarts at KEY_START.
- rst_n low while in DECRYPT -> all outputs at reset values asynchronously; dec_done afterward ignored.
- With KEY_SEARCH_HEX_DISPLAY_EN, found key 24'h00A3F1 -> HEX0='1', HEX1='F', HEX2='3', HEX3='A', HEX4=HEX5='0', LEDR[0]=1; without macro HEX*=7'h7F.

Source files
------------

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: brute-force RC4 key search controller.
// For each candidate key it starts the decrypt core, then scans the decrypted
// message RAM one byte per cycle. A key is accepted only when every byte is
// 'a'..'z' or space. KEY_START/KEY_STEP partition the key space across cores,
// and a shared stop input aborts the search.
// Optional build macro KEY_SEARCH_HEX_DISPLAY_EN drives the key onto HEX0..HEX5
// and the status flags onto LEDR. When it is undefined, the displays are blank.
module key_search_ctrl #(
    parameter int               MSG_LEN   = 32,
    parameter int               ADDR_W    = 5,
    parameter int               KEY_W     = 24,
    parameter logic [KEY_W-1:0] KEY_START = '0,
    parameter logic [KEY_W-1:0] KEY_STEP  = {{(KEY_W-1){1'b0}}, 1'b1},
    parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic              dec_start,
    input  logic              dec_done,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        read_byte,
    output logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              found,
    output logic              fail,
    output logic [6:0]        HEX5,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX0,
    output logic [9:0]        LEDR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECRYPT,
        S_SCAN,
        S_NEXT_KEY,
        S_FOUND,
        S_FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [KEY_W-1:0]  key_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              dec_first, dec_first_nxt;
    logic              vld_p1;
    logic [ADDR_W-1:0] chk_addr_p1;
    logic [KEY_W:0]    key_sum;
    logic              byte_ok;

    // Accepted message characters: space or lowercase letter.
    function automatic logic char_ok(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // The extra carry bit keeps the exhaustion test correct near the top of the key range.
    assign key_sum = {1'b0, key} + {1'b0, KEY_STEP};
    assign byte_ok = char_ok(read_byte);

    assign busy  = (state == S_DECRYPT) || (state == S_SCAN) || (state == S_NEXT_KEY);
    assign found = (state == S_FOUND);
    assign fail  = (state == S_FAIL);

    // Control state: FSM state, candidate key, RAM address, decrypt pulse flag, read-valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            key       <= KEY_START;
            address   <= '0;
            dec_first <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            state     <= state_nxt;
            key       <= key_nxt;
            address   <= addr_nxt;
            dec_first <= dec_first_nxt;
            vld_p1    <= (state == S_SCAN);
        end
    end

    // ---- stage p0 -> p1: the address presented now returns its byte next cycle ----
    // Tag each returning byte with the address it came from.
    always_ff @(posedge clk) begin
        chk_addr_p1 <= address;
    end

    // Next-state, key/address updates and the decrypt start pulse.
    always_comb begin
        state_nxt     = state;
        key_nxt       = key;
        addr_nxt      = address;
        dec_first_nxt = 1'b0;
        dec_start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    key_nxt       = KEY_START;
                    state_nxt     = S_DECRYPT;
                    dec_first_nxt = 1'b1;
                end
            end
            S_DECRYPT: begin
                dec_start = dec_first;
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (dec_done && !dec_first) begin
                    state_nxt = S_SCAN;
                    addr_nxt  = '0;
                end
            end
            S_SCAN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (vld_p1 && !byte_ok) begin
                    state_nxt = S_NEXT_KEY;
                end else if (vld_p1 && (chk_addr_p1 == LAST_ADDR)) begin
                    state_nxt = S_FOUND;
                end else if (address != LAST_ADDR) begin
                    addr_nxt = address + 1'b1;
                end
            end
            S_NEXT_KEY: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (key_sum > {1'b0, KEY_MAX}) begin
                    state_nxt = S_FAIL;
                end else begin
                    key_nxt       = key_sum[KEY_W-1:0];
                    state_nxt     = S_DECRYPT;
                    dec_first_nxt = 1'b1;
                end
            end
            S_FOUND, S_FAIL: begin
                if (start) begin
                    key_nxt       = KEY_START;
                    state_nxt     = S_DECRYPT;
                    dec_first_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef KEY_SEARCH_HEX_DISPLAY_EN
    logic [23:0] key_disp;

    // Active-low seven-segment pattern, bit 0 = segment a.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    if (KEY_W >= 24) begin : g_key_trunc
        assign key_disp = key[23:0];
    end else begin : g_key_ext
        assign key_disp = {{(24-KEY_W){1'b0}}, key};
    end

    // Six hex digits of the key plus the status flags on the LEDs.
    always_comb begin
        HEX0 = hex7(key_disp[3:0]);
        HEX1 = hex7(key_disp[7:4]);
        HEX2 = hex7(key_disp[11:8]);
        HEX3 = hex7(key_disp[15:12]);
        HEX4 = hex7(key_disp[19:16]);
        HEX5 = hex7(key_disp[23:20]);
        LEDR = {7'b0, busy, fail, found};
    end
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign LEDR = '0;
`endif

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: directed bench for key_search_ctrl.
// dut_a: MSG_LEN=4 search from key 0 with a small per-key message RAM model.
// dut_b: KEY_START=1, KEY_STEP=4, KEY_MAX=10 with every message invalid.
// dut_c: MSG_LEN=1, KEY_START=24'h00A3F1 for the display check.
module tb_key_search_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- dut_a ----------------
    logic        start_a = 0, stop_a = 0, dec_start_a, dec_done_a, man_done_a = 0;
    logic [1:0]  address_a;
    logic [7:0]  rd_a;
    logic [23:0] key_a;
    logic        busy_a, found_a, fail_a;
    logic [6:0]  hex_a [6];
    logic [9:0]  ledr_a;
    logic [7:0]  msg_a [4][4];
    int          cnt_a;

    key_search_ctrl #(.MSG_LEN(4), .ADDR_W(2), .KEY_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
        .dec_start(dec_start_a), .dec_done(dec_done_a), .address(address_a),
        .read_byte(rd_a), .key(key_a), .busy(busy_a), .found(found_a), .fail(fail_a),
        .HEX5(hex_a[5]), .HEX4(hex_a[4]), .HEX3(hex_a[3]), .HEX2(hex_a[2]),
        .HEX1(hex_a[1]), .HEX0(hex_a[0]), .LEDR(ledr_a));

    always @(posedge clk) rd_a <= msg_a[key_a[1:0]][address_a];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_a <= 0;
        else if (dec_start_a) cnt_a <= 3;
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    assign dec_done_a = (cnt_a == 1) || man_done_a;

    // ---------------- dut_b ----------------
    logic        start_b = 0, stop_b = 0, dec_start_b, dec_done_b;
    logic [1:0]  address_b;
    logic [7:0]  rd_b;
    logic [23:0] key_b;
    logic        busy_b, found_b, fail_b;
    logic [6:0]  hex_b [6];
    logic [9:0]  ledr_b;
    int          cnt_b;

    key_search_ctrl #(.MSG_LEN(4), .ADDR_W(2), .KEY_W(24), .KEY_START(24'd1),
                      .KEY_STEP(24'd4), .KEY_MAX(24'd10)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
        .dec_start(dec_start_b), .dec_done(dec_done_b), .address(address_b),
        .read_byte(rd_b), .key(key_b), .busy(busy_b), .found(found_b), .fail(fail_b),
        .HEX5(hex_b[5]), .HEX4(hex_b[4]), .HEX3(hex_b[3]), .HEX2(hex_b[2]),
        .HEX1(hex_b[1]), .HEX0(hex_b[0]), .LEDR(ledr_b));

    always @(posedge clk) rd_b <= 8'h41;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_b <= 0;
        else if (dec_start_b) cnt_b <= 2;
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    assign dec_done_b = (cnt_b == 1);

    // ---------------- dut_c ----------------
    logic        start_c = 0, stop_c = 0, dec_start_c, dec_done_c;
    logic [0:0]  address_c;
    logic [7:0]  rd_c;
    logic [23:0] key_c;
    logic        busy_c, found_c, fail_c;
    logic [6:0]  hex_c [6];
    logic [9:0]  ledr_c;

    key_search_ctrl #(.MSG_LEN(1), .ADDR_W(1), .KEY_W(24), .KEY_START(24'h00A3F1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c),
        .dec_start(dec_start_c), .dec_done(dec_done_c), .address(address_c),
        .read_byte(rd_c), .key(key_c), .busy(busy_c), .found(found_c), .fail(fail_c),
        .HEX5(hex_c[5]), .HEX4(hex_c[4]), .HEX3(hex_c[3]), .HEX2(hex_c[2]),
        .HEX1(hex_c[1]), .HEX0(hex_c[0]), .LEDR(ledr_c));

    always @(posedge clk) rd_c <= 8'h61;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) dec_done_c <= 1'b0;
        else dec_done_c <= dec_start_c;

    // ---------------- decrypt-start monitors ----------------
    int          pulses_a = 0, pulses_b = 0;
    logic [23:0] pk_a [$];
    logic [23:0] pk_b [$];
    logic [1:0]  pa_a [$];

    always @(posedge clk) begin
        if (dec_start_a) begin
            pulses_a = pulses_a + 1;
            pk_a.push_back(key_a);
            pa_a.push_back(address_a);
        end
        if (dec_start_b) begin
            pulses_b = pulses_b + 1;
            pk_b.push_back(key_b);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_a = 0; stop_a = 0; man_done_a = 0;
        start_b = 0; stop_b = 0; start_c = 0; stop_c = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulses_a = 0; pulses_b = 0;
        pk_a.delete(); pk_b.delete(); pa_a.delete();
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Waits for found/fail on dut_a; a timeout counts as a failed comparison.
    task automatic wait_end_a(input string name);
        int n = 0;
        while (!(found_a || fail_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(found_a || fail_a), 32'd1);
    endtask

    task automatic load_a(input int k, input logic [31:0] bytes);
        for (int j = 0; j < 4; j++) msg_a[k][j] = bytes[8*j +: 8];
    endtask

    typedef struct {
        logic [31:0] bytes;     // key-0 message, byte 0 in [7:0]
        logic [23:0] exp_key;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [8];
    logic [6:0] exp_hex [6];

    initial begin
        int n;
        vecs[0] = '{32'h7A206261, 24'd0, 1};
        vecs[1] = '{32'h61616160, 24'd1, 2};
        vecs[2] = '{32'h7B616161, 24'd1, 2};
        vecs[3] = '{32'h20202020, 24'd0, 1};
        vecs[4] = '{32'h61612161, 24'd1, 2};
        vecs[5] = '{32'h6178797A, 24'd0, 1};
        vecs[6] = '{32'h611F6161, 24'd1, 2};
        vecs[7] = '{32'h616161E1, 24'd1, 2};

        for (int k = 0; k < 4; k++) load_a(k, 32'h61616161);

        // ---- reset state ----
        do_reset();
        check("rst_key_a", 32'(key_a), 32'd0);
        check("rst_addr_a", 32'(address_a), 32'd0);
        check("rst_flags_a", {28'd0, dec_start_a, busy_a, found_a, fail_a}, 32'd0);
        check("rst_key_b", 32'(key_b), 32'd1);
        check("rst_key_c", 32'(key_c), 32'h00A3F1);

        // ---- table: character classes, key 1 always valid ----
        for (int i = 0; i < 8; i++) begin
            do_reset();
            load_a(0, vecs[i].bytes);
            pulse_start_a();
            wait_end_a($sformatf("vec%0d", i));
            check($sformatf("vec%0d_found", i), 32'(found_a), 32'd1);
            check($sformatf("vec%0d_key", i), 32'(key_a), 32'(vecs[i].exp_key));
            check($sformatf("vec%0d_pulses", i), 32'(pulses_a), 32'(vecs[i].exp_pulses));
        end

        // ---- single key: one pulse, addresses 0..3 in order ----
        do_reset();
        load_a(0, 32'h7A206261);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("seq_dec_start_hi", 32'(dec_start_a), 32'd1);
        @(negedge clk);
        check("seq_dec_start_lo", 32'(dec_start_a), 32'd0);
        n = 0;
        while (!dec_done_a && n < 20) begin @(negedge clk); n++; end
        check("seq_done_timeout", 32'(dec_done_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("seq_addr%0d", i), 32'(address_a), 32'(i));
        end
        wait_end_a("seq");
        check("seq_found", 32'(found_a), 32'd1);
        check("seq_pulses", 32'(pulses_a), 32'd1);

        // ---- three keys, early aborts ----
        do_reset();
        load_a(0, 32'h617B6261);
        load_a(1, 32'h61616061);
        load_a(2, 32'h637A2061);
        load_a(3, 32'h41414141);
        pulse_start_a();
        wait_end_a("multi");
        check("multi_found", 32'(found_a), 32'd1);
        check("multi_key", 32'(key_a), 32'd2);
        check("multi_pulses", 32'(pulses_a), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("multi_pulse_key%0d", i), 32'(pk_a[i]), 32'(i));
        check("multi_addr_after_k0", 32'(pa_a[1]), 32'd3);
        check("multi_addr_after_k1", 32'(pa_a[2]), 32'd2);
        for (int i = 0; i < 6; i++) begin
`ifdef KEY_SEARCH_HEX_DISPLAY_EN
            exp_hex[i] = (i == 0) ? 7'h24 : 7'h40;
`else
            exp_hex[i] = 7'h7F;
`endif
            check($sformatf("multi_hex%0d", i), 32'(hex_a[i]), 32'(exp_hex[i]));
        end

        // ---- partitioned key space exhausted ----
        do_reset();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!(found_b || fail_b) && n < 400) begin @(negedge clk); n++; end
        check("exh_timeout", 32'(found_b || fail_b), 32'd1);
        check("exh_fail", 32'(fail_b), 32'd1);
        check("exh_found", 32'(found_b), 32'd0);
        check("exh_busy", 32'(busy_b), 32'd0);
        check("exh_key", 32'(key_b), 32'd9);
        check("exh_pulses", 32'(pulses_b), 32'd3);
        check("exh_k0", 32'(pk_b[0]), 32'd1);
        check("exh_k1", 32'(pk_b[1]), 32'd5);
        check("exh_k2", 32'(pk_b[2]), 32'd9);
        for (int i = 0; i < 6; i++) begin
`ifdef KEY_SEARCH_HEX_DISPLAY_EN
            exp_hex[i] = (i == 0) ? 7'h10 : 7'h40;
`else
            exp_hex[i] = 7'h7F;
`endif
            check($sformatf("exh_hex%0d", i), 32'(hex_b[i]), 32'(exp_hex[i]));
        end
`ifdef KEY_SEARCH_HEX_DISPLAY_EN
        check("exh_ledr", 32'(ledr_b), 32'h002);
`else
        check("exh_ledr", 32'(ledr_b), 32'h000);
`endif

        // ---- stop mid-scan, stop+start in IDLE, restart ----
        do_reset();
        load_a(0, 32'h41414141);
        load_a(1, 32'h61616161);
        pulse_start_a();
        n = 0;
        while (!(key_a == 24'd1 && address_a == 2'd2 && busy_a) && n < 100) begin
            @(negedge clk); n++;
        end
        check("stop_reach", 32'(n < 100), 32'd1);
        stop_a = 1'b1;
        @(negedge clk);
        check("stop_flags", {29'd0, busy_a, found_a, fail_a}, 32'd0);
        check("stop_key_hold", 32'(key_a), 32'd1);
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        check("stop_start_idle", 32'(busy_a), 32'd0);
        stop_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_key", 32'(key_a), 32'd0);
        check("restart_pulse", 32'(dec_start_a), 32'd1);
        wait_end_a("restart");
        check("restart_found_key", 32'(key_a), 32'd1);

        // ---- stop beats the final valid byte ----
        do_reset();
        load_a(0, 32'h61616161);
        pulse_start_a();
        n = 0;
        while (!(address_a == 2'd3 && busy_a) && n < 100) begin @(negedge clk); n++; end
        check("prio_reach", 32'(n < 100), 32'd1);
        @(negedge clk);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        check("prio_found", 32'(found_a), 32'd0);
        check("prio_busy", 32'(busy_a), 32'd0);

        // ---- asynchronous reset while the decrypt pulse is high ----
        do_reset();
        load_a(0, 32'h41414141);
        load_a(1, 32'h61616161);
        pulse_start_a();
        n = 0;
        while (!(key_a == 24'd1 && dec_start_a) && n < 100) begin @(negedge clk); n++; end
        check("arst_reach", 32'(n < 100), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dec_start", 32'(dec_start_a), 32'd0);
        check("arst_key", 32'(key_a), 32'd0);
        check("arst_addr", 32'(address_a), 32'd0);
        check("arst_flags", {29'd0, busy_a, found_a, fail_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_done_a = 1'b1;
        @(negedge clk);
        man_done_a = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_done_ignored", {29'd0, busy_a, found_a, fail_a}, 32'd0);
        check("arst_done_addr", 32'(address_a), 32'd0);

        // ---- display of a found key ----
        do_reset();
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        n = 0;
        while (!(found_c || fail_c) && n < 50) begin @(negedge clk); n++; end
        check("disp_found", 32'(found_c), 32'd1);
        check("disp_key", 32'(key_c), 32'h00A3F1);
`ifdef KEY_SEARCH_HEX_DISPLAY_EN
        exp_hex = '{7'h79, 7'h0E, 7'h30, 7'h08, 7'h40, 7'h40};
        check("disp_ledr", 32'(ledr_c), 32'h001);
`else
        exp_hex = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        check("disp_ledr", 32'(ledr_c), 32'h000);
`endif
        for (int i = 0; i < 6; i++)
            check($sformatf("disp_hex%0d", i), 32'(hex_c[i]), 32'(exp_hex[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
